demux_1to8: RTL and testbench



---
 rtl/demux_1to8.sv | 127 ++++++++++++
 tb/tb_demux_1to8.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1to8.sv
// -----------------------------------------------------------------------------
// demux_1to8 : registered 1-to-8 demultiplexer
//
// Steers a WIDTH-bit input word onto one of eight output lanes chosen by a
// 3-bit select.
// - Every lane that is not selected is driven to zero.
// - When the enable is low, all lanes are zero.
// - All outputs come from a single register stage, so latency is one clock.
//
// Optional build macro:
//   DEMUX_1TO8_HIT_CNT_EN - adds eight saturating per-lane hit counters and
//                           the hit_cnt output port.
//
// Parameters:
//   WIDTH  - bit width of the input word and of each output lane
//   CNT_W  - width of each hit counter (used only with the macro)
//
// Ports:
//   clk      in   1          rising-edge clock
//   rst      in   1          synchronous active-high reset (priority over en)
//   in       in   WIDTH      data word to route
//   en       in   1          routing enable
//   sel      in   3          destination lane index 0..7
//   out      out  8*WIDTH    lane k at out[k*WIDTH +: WIDTH]
//   out_vld  out  1          registered copy of en
//   out_sel  out  3          registered sel, captured only while en=1
//   hit_cnt  out  8*CNT_W    per-lane hit counters (macro only)
// -----------------------------------------------------------------------------
module demux_1to8 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in,
    input  logic               en,
    input  logic [2:0]         sel,
    output logic [8*WIDTH-1:0] out,
    output logic               out_vld,
    output logic [2:0]         out_sel
`ifdef DEMUX_1TO8_HIT_CNT_EN
    ,
    output logic [8*CNT_W-1:0] hit_cnt
`endif
);

    // Both widths feed part-selects, so a zero width would collapse the lanes.
    if (WIDTH < 1) begin : g_bad_width
        $error("demux_1to8: WIDTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("demux_1to8: CNT_W must be at least 1");
    end

    logic [8*WIDTH-1:0] out_nxt_s;
    logic [7:0]         hit_s;
    logic [8*WIDTH-1:0] out_r;
    logic               vld_r;
    logic [2:0]         sel_r;

    // Lane decode: one-hot hit vector, qualified by en.
    always_comb begin
        hit_s = 8'b0000_0000;
        for (int k = 0; k < 8; k++) begin
            if (en && (sel == 3'(k))) begin
                hit_s[k] = 1'b1;
            end else begin
                hit_s[k] = 1'b0;
            end
        end
    end

    // Steering: the selected lane carries the input word, every other lane is zero.
    always_comb begin
        out_nxt_s = '0;
        for (int k = 0; k < 8; k++) begin
            if (hit_s[k]) begin
                out_nxt_s[k*WIDTH +: WIDTH] = in;
            end else begin
                out_nxt_s[k*WIDTH +: WIDTH] = '0;
            end
        end
    end

    // Output register stage. out_sel holds its last routed index while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= '0;
            vld_r <= 1'b0;
            sel_r <= 3'b000;
        end else begin
            out_r <= out_nxt_s;
            vld_r <= en;
            if (en) begin
                sel_r <= sel;
            end else begin
                sel_r <= sel_r;
            end
        end
    end

    assign out     = out_r;
    assign out_vld = vld_r;
    assign out_sel = sel_r;

`ifdef DEMUX_1TO8_HIT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r [8];

    for (genvar k = 0; k < 8; k++) begin : g_hit_cnt
        // Per-lane hit counter. It saturates at all-ones, and only rst clears it.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_r[k] <= '0;
            end else if (hit_s[k] && (cnt_r[k] != CNT_MAX)) begin
                cnt_r[k] <= cnt_r[k] + CNT_W'(1);
            end else begin
                cnt_r[k] <= cnt_r[k];
            end
        end

        assign hit_cnt[k*CNT_W +: CNT_W] = cnt_r[k];
    end
`endif

endmodule

// File: tb/tb_demux_1to8.sv
// -----------------------------------------------------------------------------
// tb_demux_1to8 : self-checking bench for demux_1to8
//
// Two instances share rst/en/sel:
//   dut1 - WIDTH=1, default CNT_W
//   dut8 - WIDTH=8, CNT_W=2
//
// Expected values come from a behavioural model:
//   - the lane word is the input shifted up by sel*WIDTH
//   - the counters are plain integers clamped at 2^CNT_W-1
// Directed steps are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_demux_1to8;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  sel;
    logic        in1;
    logic [7:0]  in8;

    logic [7:0]  out1;
    logic        vld1;
    logic [2:0]  osel1;
    logic [63:0] out8;
    logic        vld8;
    logic [2:0]  osel8;
`ifdef DEMUX_1TO8_HIT_CNT_EN
    logic [63:0] hc1;
    logic [15:0] hc8;
`endif

    // Reference model state.
    logic [7:0]  exp_out1;
    logic [63:0] exp_out8;
    logic        exp_vld;
    logic [2:0]  exp_sel;
    int          cnt1 [8];
    int          cnt8 [8];

    int checks = 0;
    int errors = 0;

    demux_1to8 #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .in      (in1),
        .en      (en),
        .sel     (sel),
        .out     (out1),
        .out_vld (vld1),
        .out_sel (osel1)
`ifdef DEMUX_1TO8_HIT_CNT_EN
        ,
        .hit_cnt (hc1)
`endif
    );

    demux_1to8 #(.WIDTH(8), .CNT_W(2)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .in      (in8),
        .en      (en),
        .sel     (sel),
        .out     (out8),
        .out_vld (vld8),
        .out_sel (osel8)
`ifdef DEMUX_1TO8_HIT_CNT_EN
        ,
        .hit_cnt (hc8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out1",  64'(out1),  64'(exp_out1));
        chk("vld1",  64'(vld1),  64'(exp_vld));
        chk("osel1", 64'(osel1), 64'(exp_sel));
        chk("out8",  out8,       exp_out8);
        chk("vld8",  64'(vld8),  64'(exp_vld));
        chk("osel8", 64'(osel8), 64'(exp_sel));
`ifdef DEMUX_1TO8_HIT_CNT_EN
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("hc1[%0d]", k), 64'(hc1[k*8 +: 8]), 64'(cnt1[k]));
            chk($sformatf("hc8[%0d]", k), 64'(hc8[k*2 +: 2]), 64'(cnt8[k]));
        end
`endif
    endtask

    // Apply one cycle of stimulus at the falling edge, advance the model,
    // then compare on the next falling edge.
    task automatic step(input logic r, input logic e, input logic [2:0] s,
                        input logic i1, input logic [7:0] i8);
        rst = r; en = e; sel = s; in1 = i1; in8 = i8;
        if (r) begin
            exp_out1 = 8'h00;
            exp_out8 = 64'h0;
            exp_vld  = 1'b0;
            exp_sel  = 3'b000;
            for (int k = 0; k < 8; k++) begin
                cnt1[k] = 0;
                cnt8[k] = 0;
            end
        end else begin
            exp_vld = e;
            if (e) begin
                exp_out1 = 8'(i1) << int'(s);
                exp_out8 = 64'(i8) << (8 * int'(s));
                exp_sel  = s;
                cnt1[s]  = (cnt1[s] + 1 > 255) ? 255 : cnt1[s] + 1;
                cnt8[s]  = (cnt8[s] + 1 > 3)   ? 3   : cnt8[s] + 1;
            end else begin
                exp_out1 = 8'h00;
                exp_out8 = 64'h0;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [7:0] walk;
        int         hc_exp [5];

        rst = 1'b1; en = 1'b0; sel = 3'd0; in1 = 1'b0; in8 = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state.
        step(1'b1, 1'b0, 3'd0, 1'b0, 8'h00);

        // Sweep sel 0..7 with in=1. The lane bit walks 01, 02, ... 80.
        walk = 8'h01;
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 1'b1, 3'(s), 1'b1, 8'(s + 1));
            chk("sweep_lit", 64'(out1), 64'(walk));
            walk = walk << 1;
        end

        // en=0: lanes clear, valid drops, out_sel holds 7.
        step(1'b0, 1'b0, 3'd2, 1'b1, 8'hFF);
        chk("en0_sel_hold", 64'(osel1), 64'(3'd7));
        step(1'b0, 1'b1, 3'd7, 1'b1, 8'h3C);
        chk("en1_lane7", 64'(out1), 64'(8'h80));

        // in=0 with en=1 gives zero lanes but valid=1.
        step(1'b0, 1'b1, 3'd7, 1'b0, 8'h00);
        chk("zero_in_vld", 64'({vld1, out1}), 64'({1'b1, 8'h00}));
        step(1'b0, 1'b1, 3'd7, 1'b1, 8'h01);

        // Reset takes priority over en mid-stream; routing resumes right after.
        step(1'b1, 1'b1, 3'd3, 1'b1, 8'h77);
        step(1'b0, 1'b1, 3'd3, 1'b1, 8'h77);
        chk("post_rst_lane3", 64'(out1), 64'(8'h08));

        // WIDTH=8 routing of A5 to lane 5.
        step(1'b0, 1'b1, 3'd5, 1'b0, 8'hA5);
        chk("w8_lane5", out8, 64'h0000_A500_0000_0000);

        // Counter saturation on lane 2 with CNT_W=2.
        step(1'b1, 1'b0, 3'd0, 1'b0, 8'h00);
        hc_exp = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 3'd2, 1'b1, 8'h11);
`ifdef DEMUX_1TO8_HIT_CNT_EN
            chk("hc8_lane2_lit", 64'(hc8[5:4]), 64'(hc_exp[i]));
`endif
        end

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
